// File: rtl/cdc_pkg.sv
// Shared types and helpers for the single-bit clock-domain-crossing receivers.
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } bit_sync_state_t;

  // Ceiling log2 usable in constant expressions for counter sizing.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_sync_chain.sv
// Plain N-flop synchronizer: no logic between stages so the metastability
// settling window of each flop is a full clock period.
module bit_sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= {SYNC_STAGES{INIT}};
    end else begin
      s <= {s[SYNC_STAGES-2:0], d};
    end
  end

  assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/bit_sync_rx.sv
// Receive side of a single-bit crossing: synchronizer, stability filter,
// edge pulses and a saturating count of rejected (too short) changes.
module bit_sync_rx
  import cdc_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic INIT          = 1'b0,
  parameter int   GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                async_in,
  input  logic                glitch_clr,
  output logic                sync_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                change_pulse,
  output logic                stable,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            cand;
  bit_sync_state_t state;
  logic [CNT_W-1:0] cnt;
  logic            differs;
  logic            resolved;
  logic            reject;

  bit_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .INIT       (INIT)
  ) u_chain (
    .clk(clk),
    .rst(rst),
    .d  (async_in),
    .q  (cand)
  );

  // An unknown candidate counts as "differs" but may only be accepted once it
  // has resolved to the opposite of the current level.
  assign differs  = (cand !== sync_out);
  assign resolved = (cand === ~sync_out);
  assign reject   = (state == QUAL) && !differs;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out   <= INIT;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch_cnt <= '0;
      cnt        <= '0;
      state      <= IDLE;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;

      if (glitch_clr) begin
        glitch_cnt <= '0;
      end else if (reject && (glitch_cnt != {GLITCH_W{1'b1}})) begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (differs) begin
            if (FILTER_CYCLES == 1) begin
              if (resolved) begin
                sync_out   <= cand;
                rise_pulse <= cand;
                fall_pulse <= ~cand;
              end
            end else begin
              cnt   <= CNT_ONE;
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!differs) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            // Hold at the final count while the candidate is still unknown.
            if (resolved) begin
              sync_out   <= cand;
              rise_pulse <= cand;
              fall_pulse <= ~cand;
              cnt        <= '0;
              state      <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign change_pulse = rise_pulse | fall_pulse;
  assign stable       = (state == IDLE);

endmodule

// File: tb/tb_bit_sync_rx.sv
// Bench for bit_sync_rx: default instance plus an unfiltered 3-stage instance,
// with expected pulses queued at drive time and matched when they appear.
module tb_bit_sync_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, async_a, async_b, glitch_clr;
  logic       sync_a, rise_a, fall_a, chg_a, stable_a;
  logic       sync_b, rise_b, fall_b, chg_b, stable_b;
  logic [7:0] gcnt_a, gcnt_b;

  bit_sync_rx dut_a (
    .clk(clk), .rst(rst), .async_in(async_a), .glitch_clr(glitch_clr),
    .sync_out(sync_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .change_pulse(chg_a), .stable(stable_a), .glitch_cnt(gcnt_a)
  );

  bit_sync_rx #(.SYNC_STAGES(3), .FILTER_CYCLES(1), .INIT(1'b0), .GLITCH_W(8)) dut_b (
    .clk(clk), .rst(rst), .async_in(async_b), .glitch_clr(glitch_clr),
    .sync_out(sync_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .change_pulse(chg_b), .stable(stable_b), .glitch_cnt(gcnt_b)
  );

  typedef struct {
    int   cyc;
    logic rise;
  } ev_t;

  typedef struct {
    logic val;
    int   hold;
    logic acc;
  } vec_t;

  ev_t  q_a[$];
  ev_t  q_b[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   chg_seen_a = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int sel, input logic r, input logic f, input logic c, input logic s);
    ev_t e;
    int  n;
    chk(sel ? "b_change_is_or" : "a_change_is_or", int'(c), int'(r | f));
    if (sel == 0 && c) chg_seen_a++;
    n = sel ? q_b.size() : q_a.size();
    if (n > 0) begin
      e = sel ? q_b[0] : q_a[0];
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s_missing_pulse: got none expected pulse at cycle %0d", sel ? "b" : "a", e.cyc);
        if (sel) void'(q_b.pop_front()); else void'(q_a.pop_front());
        n = n - 1;
        if (n > 0) e = sel ? q_b[0] : q_a[0];
      end
    end
    if (r | f) begin
      if (n > 0 && e.cyc == cyc) begin
        chk(sel ? "b_rise" : "a_rise", int'(r), int'(e.rise));
        chk(sel ? "b_fall" : "a_fall", int'(f), int'(!e.rise));
        chk(sel ? "b_level" : "a_level", int'(s), int'(e.rise));
        if (sel) void'(q_b.pop_front()); else void'(q_a.pop_front());
      end else begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_pulse: got rise=%0d fall=%0d expected none at cycle %0d",
                 sel ? "b" : "a", r, f, cyc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    mon(0, rise_a, fall_a, chg_a, sync_a);
    mon(1, rise_b, fall_b, chg_b, sync_b);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Input changes land at an arbitrary point inside the cycle, as from an unrelated clock.
  task automatic drive_a(input logic v);
    #($urandom_range(0, 7));
    async_a = v;
  endtask

  task automatic expect_a(input int at, input logic v);
    ev_t e;
    e.cyc = at;
    e.rise = v;
    q_a.push_back(e);
  endtask

  task automatic glitch_a();
    drive_a(1'b1);
    step();
    drive_a(1'b0);
    steps(6);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int edges;
    int base;
    logic v;

    vecs[0] = '{1'b1, 3, 1'b0};
    vecs[1] = '{1'b0, 6, 1'b0};
    vecs[2] = '{1'b1, 4, 1'b1};
    vecs[3] = '{1'b0, 4, 1'b1};
    vecs[4] = '{1'b1, 1, 1'b0};
    vecs[5] = '{1'b0, 6, 1'b0};
    vecs[6] = '{1'b1, 8, 1'b1};
    vecs[7] = '{1'b0, 3, 1'b0};
    vecs[8] = '{1'b1, 6, 1'b0};
    vecs[9] = '{1'b0, 10, 1'b1};

    rst = 1'b1; async_a = 1'b0; async_b = 1'b0; glitch_clr = 1'b0;
    steps(3);
    chk("rst_sync", sync_a, 0);
    chk("rst_rise", rise_a, 0);
    chk("rst_fall", fall_a, 0);
    chk("rst_glitch", gcnt_a, 0);
    chk("rst_stable", stable_a, 1);
    chk("rst_sync_b", sync_b, 0);
    rst = 1'b0;
    steps(3);

    // Clean 0->1 held 20 clocks, then back to 0.
    k = cyc;
    drive_a(1'b1);
    expect_a(k + 6, 1'b1);
    steps(2);
    chk("t1_stable_before", stable_a, 1);
    step();
    chk("t1_stable_qual", stable_a, 0);
    steps(2);
    chk("t1_sync_early", sync_a, 0);
    step();
    chk("t1_sync_edge5", sync_a, 1);
    chk("t1_stable_done", stable_a, 1);
    steps(14);
    chk("t1_glitch", gcnt_a, 0);
    k = cyc;
    drive_a(1'b0);
    expect_a(k + 6, 1'b0);
    steps(10);
    chk("t1_sync_low", sync_a, 0);

    // Table of input levels and hold lengths.
    for (int i = 0; i < 10; i++) begin
      k = cyc;
      drive_a(vecs[i].val);
      if (vecs[i].acc) expect_a(k + 6, vecs[i].val);
      steps(vecs[i].hold);
    end
    steps(10);
    chk("tbl_glitch", gcnt_a, 3);
    chk("tbl_sync", sync_a, 0);

    // Clear coinciding with a reject wins.
    k = cyc;
    drive_a(1'b1);
    step();
    drive_a(1'b0);
    steps(2);
    chk("clr_pre", gcnt_a, 3);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("clr_with_reject", gcnt_a, 0);
    steps(4);
    chk("clr_no_late_inc", gcnt_a, 0);
    for (int i = 0; i < 7; i++) glitch_a();
    chk("clr_seven", gcnt_a, 7);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("clr_alone", gcnt_a, 0);

    // Saturation of the glitch counter.
    for (int i = 1; i <= 300; i++) begin
      glitch_a();
      chk("sat_count", gcnt_a, (i > 255) ? 255 : i);
    end
    chk("sat_sync", sync_a, 0);

    // Reset while qualifying a rise with cnt=2.
    k = cyc;
    drive_a(1'b1);
    steps(4);
    chk("rstq_qualifying", stable_a, 0);
    rst = 1'b1;
    step();
    chk("rstq_sync", sync_a, 0);
    chk("rstq_rise", rise_a, 0);
    chk("rstq_fall", fall_a, 0);
    chk("rstq_glitch", gcnt_a, 0);
    chk("rstq_stable", stable_a, 1);
    rst = 1'b0;
    expect_a(k + 11, 1'b1);
    steps(12);
    chk("rstq_sync_after", sync_a, 1);
    chk("rstq_glitch_after", gcnt_a, 0);
    k = cyc;
    drive_a(1'b0);
    expect_a(k + 6, 1'b0);
    steps(10);

    // Randomly spaced changes: one pulse per input edge.
    base = chg_seen_a;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      k = cyc;
      v = ~async_a;
      drive_a(v);
      expect_a(k + 6, v);
      edges++;
      steps($urandom_range(5, 12));
    end
    steps(10);
    chk("rand_edge_count", chg_seen_a - base, edges);
    chk("rand_glitch", gcnt_a, 0);

    // Unfiltered 3-stage instance, toggling every 4 clocks.
    for (int i = 0; i < 8; i++) begin
      k = cyc;
      v = ~async_b;
      #($urandom_range(0, 7));
      async_b = v;
      q_b.push_back('{k + 4, v});
      for (int j = 0; j < 4; j++) begin
        step();
        chk("b_stable", stable_b, 1);
      end
    end
    steps(6);
    chk("b_glitch", gcnt_b, 0);
    chk("b_sync_final", sync_b, async_b);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
